// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Parametrised valid/ready pipeline stage register carrying a
//             bundle of WORDS words of WORD_W bits (word 0 in the LSBs).
//             Supports a global stage enable (RegWrite), synchronous flush
//             and asynchronous active-high reset.
//  Options  : PIPE_STAGE_SKID_EN - when defined, a 2-entry skid buffer is
//             built and OReady depends only on registered state. When
//             undefined, a single slot is used and OReady is combinational
//             from IReady.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int WORD_W = 16,
    parameter int WORDS  = 3
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      RegWrite,
    input  logic                      Flush,
    input  logic                      IValid,
    input  logic [WORD_W*WORDS-1:0]   IData,
    output logic                      OReady,
    output logic                      OValid,
    output logic [WORD_W*WORDS-1:0]   OData,
    input  logic                      IReady,
    output logic [1:0]                OCount
);

    localparam int B = WORD_W * WORDS;

    // Encoding doubles as the occupancy count driven on OCount.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t         state;
    logic [B-1:0]   main_data;
`ifdef PIPE_STAGE_SKID_EN
    logic [B-1:0]   skid_data;
`endif
    logic           push;
    logic           pop;

    // Handshake outputs and transfer qualifiers derived from held state.
    always_comb begin
        OValid = (state != S_EMPTY) && RegWrite;
`ifdef PIPE_STAGE_SKID_EN
        // Registered-state only: a downstream stall never reaches upstream
        // combinationally, the skid slot absorbs the in-flight beat.
        OReady = (state != S_TWO) && RegWrite && !Reset;
`else
        OReady = (!OValid || IReady) && RegWrite && !Reset;
`endif
        push   = IValid && OReady && RegWrite && !Flush;
        pop    = OValid && IReady && RegWrite;
        OData  = main_data;
        OCount = state;
    end

    // Slot and state update; emptied slots are zeroed so OData reads 0 when idle.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= S_EMPTY;
            main_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_data <= '0;
`endif
        end else if (RegWrite) begin
            if (Flush) begin
                // Flush wins over any concurrent push or pop.
                state     <= S_EMPTY;
                main_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
                skid_data <= '0;
`endif
            end else begin
                case (state)
                    S_EMPTY: begin
                        if (push) begin
                            state     <= S_ONE;
                            main_data <= IData;
                        end
                    end
                    S_ONE: begin
                        if (push && pop) begin
                            main_data <= IData;
                        end else if (push) begin
`ifdef PIPE_STAGE_SKID_EN
                            state     <= S_TWO;
                            skid_data <= IData;
`else
                            // Unreachable without the skid slot: OReady
                            // requires IReady while holding an entry.
                            main_data <= IData;
`endif
                        end else if (pop) begin
                            state     <= S_EMPTY;
                            main_data <= '0;
                        end
                    end
`ifdef PIPE_STAGE_SKID_EN
                    S_TWO: begin
                        if (pop) begin
                            state     <= S_ONE;
                            main_data <= skid_data;
                            skid_data <= '0;
                        end
                    end
`endif
                    default: begin
                        state     <= S_EMPTY;
                        main_data <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Self-checking bench for pipe_stage_reg: a FIFO scoreboard
//             tracks accepted bundles and is compared every cycle, plus a
//             vector table and directed corner-case sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int WORD_W = 16;
    localparam int WORDS  = 3;
    localparam int B      = WORD_W * WORDS;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          CLK = 1'b0;
    logic          Reset;
    logic          RegWrite;
    logic          Flush;
    logic          IValid;
    logic [B-1:0]  IData;
    logic          OReady;
    logic          OValid;
    logic [B-1:0]  OData;
    logic          IReady;
    logic [1:0]    OCount;

    pipe_stage_reg #(.WORD_W(WORD_W), .WORDS(WORDS)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .RegWrite (RegWrite),
        .Flush    (Flush),
        .IValid   (IValid),
        .IData    (IData),
        .OReady   (OReady),
        .OValid   (OValid),
        .OData    (OData),
        .IReady   (IReady),
        .OCount   (OCount)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: bundles accepted by the stage, oldest first.
    logic [B-1:0] exp_q[$];
    bit           exp_push;
    bit           exp_pop;

    typedef struct {
        logic          rw;
        logic          fl;
        logic          iv;
        logic [B-1:0]  d;
        logic          ir;
        logic          ev;
        logic [B-1:0]  ed;
        logic [1:0]    ec;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare the stage outputs against the scoreboard with inputs stable.
    task automatic model_check();
        logic          ev;
        logic          er;
        logic [B-1:0]  ed;
        int            sz;
        sz = exp_q.size();
        ev = RegWrite && (sz > 0);
        if (CAP == 2) er = RegWrite && (sz < 2);
        else          er = RegWrite && ((sz == 0) || IReady);
        ed = (sz > 0) ? exp_q[0] : '0;
        chk("m_ovalid", 64'(OValid), 64'(ev));
        chk("m_oready", 64'(OReady), 64'(er));
        chk("m_ocount", 64'(OCount), 64'(sz));
        chk("m_odata",  64'(OData),  64'(ed));
        exp_push = IValid && er && RegWrite && !Flush;
        exp_pop  = ev && IReady && RegWrite;
    endtask

    // One clock cycle: drive, check at negedge, update model at posedge.
    task automatic step(input logic rw, input logic fl, input logic iv,
                        input logic [B-1:0] d, input logic ir);
        RegWrite = rw;
        Flush    = fl;
        IValid   = iv;
        IData    = d;
        IReady   = ir;
        @(negedge CLK);
        model_check();
        @(posedge CLK);
        if (rw) begin
            if (fl) exp_q.delete();
            else begin
                if (exp_pop)  void'(exp_q.pop_front());
                if (exp_push) exp_q.push_back(d);
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [B-1:0] a_val;
        logic [B-1:0] b_val;
        a_val = 48'h0A0A_1111_2222;
        b_val = 48'h0B0B_3333_4444;

        // Streaming vectors: inputs, then expected outputs after the edge.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 48'h000001, 1'b1, 1'b1, 48'h000001, 2'd1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 48'h000002, 1'b1, 1'b1, 48'h000002, 2'd1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 48'h000003, 1'b1, 1'b1, 48'h000003, 2'd1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 48'h000004, 1'b1, 1'b1, 48'h000004, 2'd1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 48'h000000, 1'b1, 1'b0, 48'h000000, 2'd0};

        // Reset held while upstream offers a bundle.
        Reset    = 1'b1;
        RegWrite = 1'b1;
        Flush    = 1'b0;
        IValid   = 1'b1;
        IData    = 48'h1234_5678_9abc;
        IReady   = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("rst_ovalid", 64'(OValid), 64'd0);
        chk("rst_odata",  64'(OData),  64'd0);
        chk("rst_oready", 64'(OReady), 64'd0);
        chk("rst_ocount", 64'(OCount), 64'd0);
        Reset = 1'b0;
        step(1'b1, 1'b0, 1'b1, 48'h1234_5678_9abc, 1'b0);
        chk("rel_ovalid", 64'(OValid), 64'd1);
        chk("rel_odata",  64'(OData),  64'h1234_5678_9abc);
        drain();

        // Table-driven stream, one per cycle with downstream ready.
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].rw, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ir);
            chk($sformatf("tbl%0d_ovalid", i), 64'(OValid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_odata", i),  64'(OData),  64'(tbl[i].ed));
            chk($sformatf("tbl%0d_ocount", i), 64'(OCount), 64'(tbl[i].ec));
        end

        // Downstream stall while a second beat is offered.
        step(1'b1, 1'b0, 1'b1, a_val, 1'b0);
        step(1'b1, 1'b0, 1'b1, b_val, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
        chk("skid_ocount", 64'(OCount), 64'd2);
        chk("skid_oready", 64'(OReady), 64'd0);
        chk("skid_odata",  64'(OData),  64'(a_val));
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("skid_pop1_data",  64'(OData),  64'(b_val));
        chk("skid_pop1_count", 64'(OCount), 64'd1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("skid_pop2_count", 64'(OCount), 64'd0);
`else
        chk("stall_ocount", 64'(OCount), 64'd1);
        chk("stall_odata",  64'(OData),  64'(a_val));
`endif
        drain();

        // Stage disabled while holding A and upstream offers new data.
        step(1'b1, 1'b0, 1'b1, a_val, 1'b0);
        step(1'b0, 1'b1, 1'b1, 48'hFFFF_AAAA_FFFF, 1'b1);
        chk("hold_ovalid", 64'(OValid), 64'd0);
        chk("hold_oready", 64'(OReady), 64'd0);
        chk("hold_odata",  64'(OData),  64'(a_val));
        chk("hold_ocount", 64'(OCount), 64'd1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("resume_ovalid", 64'(OValid), 64'd1);
        chk("resume_odata",  64'(OData),  64'(a_val));

        // Flush with the stage full and a new beat offered.
        step(1'b1, 1'b0, 1'b1, b_val, 1'b0);
        step(1'b1, 1'b1, 1'b1, 48'hDEAD_BEEF_0001, 1'b0);
        chk("flush_ocount", 64'(OCount), 64'd0);
        chk("flush_ovalid", 64'(OValid), 64'd0);
        chk("flush_odata",  64'(OData),  64'd0);
        drain();

        // Flush coinciding with push and pop.
        step(1'b1, 1'b0, 1'b1, a_val, 1'b0);
        step(1'b1, 1'b1, 1'b1, b_val, 1'b1);
        chk("flushpp_ocount", 64'(OCount), 64'd0);
        drain();

        // Short asynchronous reset pulse between edges with the stage full.
        step(1'b1, 1'b0, 1'b1, a_val, 1'b0);
        step(1'b1, 1'b0, 1'b1, b_val, 1'b0);
        IValid = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_ovalid", 64'(OValid), 64'd0);
        chk("arst_odata",  64'(OData),  64'd0);
        chk("arst_ocount", 64'(OCount), 64'd0);
        chk("arst_oready", 64'(OReady), 64'd0);
        exp_q.delete();
        #2;
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        drain();

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 1)),
                 {16'($urandom), 32'($urandom)},
                 ($urandom_range(0, 2) != 0));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that generalises the fixed 16-bit IF/ID latch into an N-word, valid/ready-handshaked stage with flush and an optional 2-entry skid buffer. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM). It carries a bundle of WORDS words (e.g. PC+2, PC, IR) with back-pressure, so a downstream stall never drops or duplicates an instruction.

## Interface
- WORD_W, 16, width of one word
- WORDS, 3, words per bundle; bundle width B = WORD_W*WORDS, word 0 in bits [WORD_W-1:0]
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- RegWrite  in  1  global stage enable; 0 freezes all state
- Flush  in  1  synchronous discard of all held entries
- IValid  in  1  upstream bundle valid
- IData  in  B  upstream bundle
- OReady  out  1  stage can accept (to upstream)
- OValid  out  1  output bundle valid (to downstream)
- OData  out  B  oldest held bundle
- IReady  in  1  downstream can accept
- OCount  out  2  entries held (0..2)

## Operation
- push = IValid & OReady & RegWrite & ~Flush; pop = OValid & IReady & RegWrite.
- Two storage slots, main (drives OData) and skid; FIFO order, OData always the oldest entry.
- States: EMPTY (OCount=0), ONE (1), TWO (2, skid build only).
- EMPTY: push → ONE, main=IData.
- ONE: push&pop → ONE, main=IData; push&~pop → TWO, skid=IData; pop&~push → EMPTY.
- TWO: pop → ONE, main=skid, skid=0; push is impossible (OReady=0).
- Flush (RegWrite=1): next state EMPTY, main and skid cleared to 0; a pop in the same cycle still counts as consumed; the incoming beat is dropped.
- RegWrite=0: state, main and skid held; OValid masked to 0; OReady forced 0; OData keeps its value; Flush ignored.
- Emptied slots are cleared to 0, so OData=0 whenever OValid=0 and RegWrite=1.
- OValid = (state≠EMPTY) & RegWrite.

## Timing
- Reset (async, immediate): state EMPTY, OData=0, OValid=0, OCount=0, OReady=0 while Reset=1. OReady=1 in the first cycle after deassertion (RegWrite=1).
- Reset mid-operation discards both slots immediately. No partial update occurs on the deasserting edge.
- Latency: IData accepted at edge n appears on OData/OValid after edge n when the stage was empty. Sustained throughput is 1 bundle/cycle with IReady=1.
- Handshake: IValid/IData must hold until push. OValid/OData hold until pop, and change only on a CLK edge or on Reset.
- Skid build: OReady = (state≠TWO) & RegWrite & ~Reset, a registered-state function with no combinational path from IReady. A downstream stall absorbs one extra in-flight beat.
- Simultaneous push, pop and Flush: flush wins; next state EMPTY.

## Configuration
- PIPE_STAGE_SKID_EN defined: 2-entry skid buffer as above; OCount ranges 0..2; OReady independent of IReady.
- Undefined: single slot (states EMPTY/ONE only); OReady = (~OValid | IReady) & RegWrite & ~Reset, combinational from IReady; push&pop replaces main in the same edge; OCount ∈ {0,1}. All other behaviour is identical.

## Test plan
- Reset=1 with IValid=1, IData=0x1234_5678_9abc, RegWrite=1 → OValid=0, OData=0, OReady=0, OCount=0. Release Reset, one edge → OValid=1, OData=0x1234_5678_9abc.
- Stream 0x000001…0x000004, one per cycle, IReady=1 → OData shows each one cycle later, in order; OCount stays 1; no gaps.
- Skid build: OValid=1 holding A, IReady=0, push B → OCount=2, OReady=0, OData=A. IReady=1 → A popped, then B; OCount 2→1→0.
- RegWrite=0 while holding A with IValid=1 (IData=0xFFFF_AAAA_FFFF) → OValid=0, OReady=0, OData=A unchanged, OCount unchanged. RegWrite=1 → OValid=1 with A.
- Flush with OCount=2 and IValid=1 → next cycle OCount=0, OValid=0, OData=0; the flushed-cycle input is never output.
- Async Reset pulse (<1 cycle) between edges with OCount=2 → outputs zero immediately; no stale entry appears after release.
